// File: rtl/cr_kme_key_asm_pkg.sv
// Shared types and default geometry for the KME key assembler.
// The optional key_par output is controlled by CR_KME_KEY_ASM_PARITY_EN.
package cr_kme_key_asm_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } key_asm_state_e;

  localparam int unsigned KEY_ASM_IN_WIDTH  = 64;
  localparam int unsigned KEY_ASM_WORDS     = 4;
  localparam int unsigned KEY_ASM_CNT_WIDTH = 16;
  localparam int unsigned KEY_W             = KEY_ASM_IN_WIDTH * KEY_ASM_WORDS;

  // Slot index width; never narrower than one bit.
  function automatic int unsigned key_asm_idx_w(input int unsigned words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cr_kme_key_asm_slot.sv
// One word slot of the key record: data register, valid bit and, when
// CR_KME_KEY_ASM_PARITY_EN is defined, the word's even-parity bit.
module cr_kme_key_asm_slot #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         v
`ifdef CR_KME_KEY_ASM_PARITY_EN
  , output logic       p
`endif
);

  // load wins over clr so the handshake cycle can clear and refill slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      v <= 1'b0;
    end else if (load) begin
      q <= d;
      v <= 1'b1;
    end else if (clr) begin
      q <= '0;
      v <= 1'b0;
    end
  end

`ifdef CR_KME_KEY_ASM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       p <= 1'b0;
    else if (load) p <= ^d;
    else if (clr)  p <= 1'b0;
  end
`endif

endmodule

// File: rtl/cr_kme_key_asm.sv
// KME key assembler: pops FIFO words and packs WORDS of them into one key
// record on a valid/ready interface. Optional key_par via CR_KME_KEY_ASM_PARITY_EN.
module cr_kme_key_asm
  import cr_kme_key_asm_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = KEY_ASM_IN_WIDTH,
  parameter int unsigned WORDS     = KEY_ASM_WORDS,
  parameter int unsigned CNT_WIDTH = KEY_ASM_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  output logic                      in_ack,
  input  logic                      flush,
  output logic [IN_WIDTH*WORDS-1:0] key_data,
  output logic [WORDS-1:0]          key_wmask,
  output logic                      key_valid,
  input  logic                      key_ready,
  output logic [CNT_WIDTH-1:0]      key_count
`ifdef CR_KME_KEY_ASM_PARITY_EN
  , output logic [WORDS-1:0]        key_par
`endif
);

  localparam int unsigned IDX_W = key_asm_idx_w(WORDS);

  key_asm_state_e   state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             flush_pend;
  logic             pop, last, close, hs;
  logic [WORDS-1:0] load;
  logic             clr;

  assign pop  = in_valid & ((state == ACCUM) | key_ready);
  assign last = (idx == IDX_W'(WORDS - 1));
  assign hs   = (state == HOLD) & key_ready;
  // A flush closes the record if any word is present, counting one popped now
  assign close = (state == ACCUM) & (flush | flush_pend) & ((|key_wmask) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if ((pop && last) || close) state_nxt = HOLD;
      HOLD:  if (key_ready)              state_nxt = ACCUM;
      default:                           state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ack    = pop;
    key_valid = (state == HOLD);
    load      = '0;
    clr       = 1'b0;
    case (state)
      ACCUM: begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (pop && (idx == IDX_W'(i))) load[i] = 1'b1;
        end
      end
      HOLD: begin
        if (key_ready) begin
          clr     = 1'b1;
          load[0] = pop;
        end
      end
      default: ;
    endcase
  end

  // flush_pend only survives in HOLD; ACCUM always consumes or drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          flush_pend <= 1'b0;
          if ((pop && last) || close) idx <= '0;
          else if (pop)               idx <= idx + 1'b1;
        end
        HOLD: begin
          if (flush)     flush_pend <= 1'b1;
          if (key_ready) idx <= IDX_W'(pop);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          key_count <= '0;
    else if (hs && (key_count != '1)) key_count <= key_count + 1'b1;
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_slot
    cr_kme_key_asm_slot #(
      .W(IN_WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[g]),
      .clr  (clr),
      .d    (in_data),
      .q    (key_data[g*IN_WIDTH +: IN_WIDTH]),
      .v    (key_wmask[g])
`ifdef CR_KME_KEY_ASM_PARITY_EN
      , .p  (key_par[g])
`endif
    );
  end

endmodule

// File: tb/tb_cr_kme_key_asm.sv
// Directed self-checking bench for cr_kme_key_asm (WORDS=4, IN_WIDTH=64).
module tb_cr_kme_key_asm;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_ack;
  logic         flush;
  logic [255:0] key_data;
  logic [3:0]   key_wmask;
  logic         key_valid;
  logic         key_ready;
  logic [15:0]  key_count;
`ifdef CR_KME_KEY_ASM_PARITY_EN
  logic [3:0]   key_par;
`endif

  int checks = 0;
  int errors = 0;

  cr_kme_key_asm #(
    .IN_WIDTH  (64),
    .WORDS     (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ack    (in_ack),
    .flush     (flush),
    .key_data  (key_data),
    .key_wmask (key_wmask),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_count (key_count)
`ifdef CR_KME_KEY_ASM_PARITY_EN
    , .key_par (key_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_word(input logic [63:0] w);
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; key_ready = 1'b0;
    #12;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", key_valid); end
    checks++; if (key_wmask !== 4'b0) begin errors++; $display("FAIL reset_wmask got %b exp 0000", key_wmask); end
    checks++; if (key_data !== 256'b0) begin errors++; $display("FAIL reset_data got %h exp 0", key_data); end
    checks++; if (key_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", key_count); end
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL reset_ack_idle got %0b exp 0", in_ack); end
`ifdef CR_KME_KEY_ASM_PARITY_EN
    checks++; if (key_par !== 4'b0) begin errors++; $display("FAIL reset_par got %b exp 0000", key_par); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full();
    key_ready = 1'b1; in_valid = 1'b1; in_data = 64'h1111_1111_1111_1111;
    #1;
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL full_ack got %0b exp 1", in_ack); end
    step();
    in_data = 64'h2222_2222_2222_2222; step();
    in_data = 64'h3333_3333_3333_3333; step();
    in_data = 64'h4444_4444_4444_4444; step();
    in_valid = 1'b0;
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %0b exp 1", key_valid); end
    checks++; if (key_wmask !== 4'b1111) begin errors++; $display("FAIL full_wmask got %b exp 1111", key_wmask); end
    checks++; if (key_data[63:0] !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL full_word0 got %h exp 1111111111111111", key_data[63:0]); end
    checks++; if (key_data[255:192] !== 64'h4444_4444_4444_4444) begin errors++; $display("FAIL full_word3 got %h exp 4444444444444444", key_data[255:192]); end
    step();
    checks++; if (key_count !== 16'd1) begin errors++; $display("FAIL full_count got %0d exp 1", key_count); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL full_drain got %0b exp 0", key_valid); end
  endtask

  task automatic test_backpressure();
    logic [255:0] exp;
    key_ready = 1'b0;
    pop_word(64'hA0A0_0000_0000_000A);
    pop_word(64'hB0B0_0000_0000_000B);
    pop_word(64'hC0C0_0000_0000_000C);
    pop_word(64'hD0D0_0000_0000_000D);
    exp = {64'hD0D0_0000_0000_000D, 64'hC0C0_0000_0000_000C,
           64'hB0B0_0000_0000_000B, 64'hA0A0_0000_0000_000A};
    in_valid = 1'b1; in_data = 64'hE0E0_0000_0000_000E;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL bp_ack[%0d] got %0b exp 0", i, in_ack); end
      checks++; if (key_data !== exp) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, key_data, exp); end
      step();
    end
    key_ready = 1'b1;
    #1;
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL bp_ack_rise got %0b exp 1", in_ack); end
    step();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %0b exp 0", key_valid); end
    checks++; if (key_wmask !== 4'b0001) begin errors++; $display("FAIL bp_wmask_slot0 got %b exp 0001", key_wmask); end
    checks++; if (key_data !== {192'b0, 64'hE0E0_0000_0000_000E}) begin errors++; $display("FAIL bp_slot0_data got %h", key_data); end
    checks++; if (key_count !== 16'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", key_count); end
    in_data = 64'hF0F0_0000_0000_000F; step();
    in_data = 64'h0101_0000_0000_0001; step();
    in_data = 64'h0202_0000_0000_0002; step();
    in_valid = 1'b0;
    exp = {64'h0202_0000_0000_0002, 64'h0101_0000_0000_0001,
           64'hF0F0_0000_0000_000F, 64'hE0E0_0000_0000_000E};
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b exp 1", key_valid); end
    checks++; if (key_data !== exp) begin errors++; $display("FAIL b2b_data got %h exp %h", key_data, exp); end
    step();
    checks++; if (key_count !== 16'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", key_count); end
  endtask

  task automatic test_flush_partial();
    key_ready = 1'b0;
    pop_word(64'h5555_5555_5555_5555);
    pop_word(64'h6666_6666_6666_6666);
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL pf_valid got %0b exp 1", key_valid); end
    checks++; if (key_wmask !== 4'b0011) begin errors++; $display("FAIL pf_wmask got %b exp 0011", key_wmask); end
    checks++; if (key_data[255:128] !== 128'b0) begin errors++; $display("FAIL pf_upper_zero got %h exp 0", key_data[255:128]); end
    checks++; if (key_data[127:0] !== {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}) begin errors++; $display("FAIL pf_lower got %h", key_data[127:0]); end
    key_ready = 1'b1; step();
    checks++; if (key_count !== 16'd4) begin errors++; $display("FAIL pf_count got %0d exp 4", key_count); end
  endtask

  task automatic test_flush_pop();
    key_ready = 1'b0;
    pop_word(64'h0000_0000_0000_00A1);
    pop_word(64'h0000_0000_0000_00A2);
    pop_word(64'h0000_0000_0000_00A3);
    flush = 1'b1;
    pop_word(64'h0000_0000_0000_00A4);
    flush = 1'b0;
    checks++; if (key_wmask !== 4'b1111) begin errors++; $display("FAIL fp_wmask got %b exp 1111", key_wmask); end
    checks++; if (key_data[255:192] !== 64'h0000_0000_0000_00A4) begin errors++; $display("FAIL fp_word3 got %h exp a4", key_data[255:192]); end
    key_ready = 1'b1; step(); key_ready = 1'b0;
    checks++; if (key_count !== 16'd5) begin errors++; $display("FAIL fp_count got %0d exp 5", key_count); end
    step();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL fp_no_extra got %0b exp 0", key_valid); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL fp_empty_flush got %0b exp 0", key_valid); end
    checks++; if (key_wmask !== 4'b0000) begin errors++; $display("FAIL fp_empty_wmask got %b exp 0000", key_wmask); end
  endtask

  task automatic test_flush_hold();
    key_ready = 1'b0;
    pop_word(64'h0000_0000_0000_00B1);
    pop_word(64'h0000_0000_0000_00B2);
    pop_word(64'h0000_0000_0000_00B3);
    pop_word(64'h0000_0000_0000_00B4);
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL fh_hold got %0b exp 1", key_valid); end
    key_ready = 1'b1;
    pop_word(64'h7777_0000_0000_7777);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL fh_accum got %0b exp 0", key_valid); end
    checks++; if (key_count !== 16'd6) begin errors++; $display("FAIL fh_count got %0d exp 6", key_count); end
    step();
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL fh_pend_valid got %0b exp 1", key_valid); end
    checks++; if (key_wmask !== 4'b0001) begin errors++; $display("FAIL fh_pend_wmask got %b exp 0001", key_wmask); end
    checks++; if (key_data !== {192'b0, 64'h7777_0000_0000_7777}) begin errors++; $display("FAIL fh_pend_data got %h", key_data); end
    key_ready = 1'b1; step(); key_ready = 1'b0;
    checks++; if (key_count !== 16'd7) begin errors++; $display("FAIL fh_count2 got %0d exp 7", key_count); end
  endtask

  task automatic test_async_reset();
    key_ready = 1'b0;
    pop_word(64'h0000_0000_0000_00C1);
    pop_word(64'h0000_0000_0000_00C2);
    #3 rst = 1'b1;
    #1;
    checks++; if (key_wmask !== 4'b0) begin errors++; $display("FAIL ar_wmask got %b exp 0000", key_wmask); end
    checks++; if (key_data !== 256'b0) begin errors++; $display("FAIL ar_data got %h exp 0", key_data); end
    checks++; if (key_count !== 16'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", key_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    pop_word(64'h0000_0000_0000_00D1);
    checks++; if (key_wmask !== 4'b0001) begin errors++; $display("FAIL ar_restart_wmask got %b exp 0001", key_wmask); end
    checks++; if (key_data[63:0] !== 64'h0000_0000_0000_00D1) begin errors++; $display("FAIL ar_restart_word0 got %h exp d1", key_data[63:0]); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ar_flush_valid got %0b exp 1", key_valid); end
    key_ready = 1'b1; step(); key_ready = 1'b0;
    checks++; if (key_count !== 16'd1) begin errors++; $display("FAIL ar_count_after got %0d exp 1", key_count); end
  endtask

`ifdef CR_KME_KEY_ASM_PARITY_EN
  task automatic test_parity();
    key_ready = 1'b0;
    pop_word(64'h0000_0000_0000_0001);
    pop_word(64'h0000_0000_0000_0003);
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (key_par !== 4'b0001) begin errors++; $display("FAIL par_bits got %b exp 0001", key_par); end
    key_ready = 1'b1; step(); key_ready = 1'b0;
    checks++; if (key_par !== 4'b0000) begin errors++; $display("FAIL par_clear got %b exp 0000", key_par); end
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_backpressure();
    test_flush_partial();
    test_flush_pop();
    test_flush_hold();
    test_async_reset();
`ifdef CR_KME_KEY_ASM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
